// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole video path: screen size, the
// 3-bit colour palette and the box_plotter state encoding.
package whack_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // box_plotter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/box_plotter.sv
// box_plotter: rasterises one filled rectangle per request into single-pixel
// writes on the 160x120 pixel bus, one slot per clock, row-major, clipping
// anything off-screen.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready; req_ready is high only in IDLE. A requester that
// sees req_ready low keeps req_valid and its fields steady until it transfers.
//
// Optional build macro WHACK_BORDER_EN: when defined, pixels on the box edge
// use req_bcolor and interior pixels use req_color.
module box_plotter
  import whack_pkg::*;
#(
  parameter  int MAX_W = 32,
  parameter  int MAX_H = 32,
  localparam int WW    = $clog2(MAX_W + 1),
  localparam int HW    = $clog2(MAX_H + 1)
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_x,
  input  logic [6:0]    req_y,
  input  logic [WW-1:0] req_w,
  input  logic [HW-1:0] req_h,
  input  logic [2:0]    req_color,
  input  logic [2:0]    req_bcolor,
  output logic [7:0]    VGA_X,
  output logic [6:0]    VGA_Y,
  output logic [2:0]    VGA_COLOR,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state_o
);

  logic [1:0]    state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [WW-1:0] w_q, w_d;
  logic [HW-1:0] h_q, h_d;
  logic [2:0]    col_q, col_d;
  logic [WW-1:0] dx_q, dx_d;
  logic [HW-1:0] dy_q, dy_d;
  // Set once the final slot has been issued (or immediately for an empty box)
  logic          end_q, end_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_col_q, vga_col_d;
  logic          plot_q, plot_d;

  logic [WW-1:0] w_clamp;
  logic [HW-1:0] h_clamp;
  logic [8:0]    px;
  logic [7:0]    py;
  logic          on_screen;
  logic          last_col;
  logic          last_row;
  logic [2:0]    pix_col;

`ifdef WHACK_BORDER_EN
  logic [2:0]    bcol_q, bcol_d;
  logic          on_border;
`else
  logic          unused_bcolor;
  assign unused_bcolor = ^req_bcolor;
`endif

  // Clamp oversize requests to the largest supported box
  always_comb begin
    w_clamp = (req_w > WW'(MAX_W)) ? WW'(MAX_W) : req_w;
    h_clamp = (req_h > HW'(MAX_H)) ? HW'(MAX_H) : req_h;
  end

  // Current slot coordinates, widened so a box hanging off the edge never wraps
  always_comb begin
    px        = {1'b0, x_q} + 9'(dx_q);
    py        = {1'b0, y_q} + 8'(dy_q);
    on_screen = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H));
    last_col  = (dx_q == w_q - WW'(1));
    last_row  = (dy_q == h_q - HW'(1));
  end

  // Per-pixel colour: edge pixels take the border colour in the border build
`ifdef WHACK_BORDER_EN
  always_comb begin
    on_border = (dx_q == '0) || last_col || (dy_q == '0) || last_row;
    pix_col   = on_border ? bcol_q : col_q;
  end
`else
  always_comb begin
    pix_col = col_q;
  end
`endif

  // Next-state logic for the FSM, scan counter and pixel outputs
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    end_d     = end_q;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;
`ifdef WHACK_BORDER_EN
    bcol_d    = bcol_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_DRAW;
          x_d     = req_x;
          y_d     = req_y;
          w_d     = w_clamp;
          h_d     = h_clamp;
          col_d   = req_color;
`ifdef WHACK_BORDER_EN
          bcol_d  = req_bcolor;
`endif
          dx_d    = '0;
          dy_d    = '0;
          end_d   = (w_clamp == '0) || (h_clamp == '0);
        end
      end
      ST_DRAW: begin
        if (end_q) begin
          state_d = ST_DONE;
        end else begin
          vga_x_d   = px[7:0];
          vga_y_d   = py[6:0];
          vga_col_d = pix_col;
          plot_d    = on_screen;
          if (last_col) begin
            dx_d = '0;
            if (last_row) begin
              end_d = 1'b1;
            end else begin
              dy_d = dy_q + HW'(1);
            end
          end else begin
            dx_d = dx_q + WW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      end_q     <= 1'b0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
      plot_q    <= 1'b0;
`ifdef WHACK_BORDER_EN
      bcol_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      end_q     <= end_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
`ifdef WHACK_BORDER_EN
      bcol_q    <= bcol_d;
`endif
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_DRAW) || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;
  assign VGA_X       = vga_x_q;
  assign VGA_Y       = vga_y_q;
  assign VGA_COLOR   = vga_col_q;
  assign plot        = plot_q;

endmodule

// File: tb/tb_box_plotter.sv
// Directed bench for box_plotter: hand-chosen boxes, an expected pixel queue
// built from a small raster model, and cycle-exact checks of done/ready.
module tb_box_plotter;

  localparam int WW = 6;
  localparam int HW = 6;

  logic          clk;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_x;
  logic [6:0]    req_y;
  logic [WW-1:0] req_w;
  logic [HW-1:0] req_h;
  logic [2:0]    req_color;
  logic [2:0]    req_bcolor;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_color;
  logic          plot;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // {plot, x, y, colour} for every slot of the current box
  logic [18:0] exp_q[$];

  box_plotter #(.MAX_W(32), .MAX_H(32)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_color  (req_color),
    .req_bcolor (req_bcolor),
    .VGA_X      (vga_x),
    .VGA_Y      (vga_y),
    .VGA_COLOR  (vga_color),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raster model: fill exp_q with the slots of one box
  task automatic model_box(input int x, input int y, input int w, input int h,
                           input logic [2:0] col, input logic [2:0] bcol);
    int ew, eh, px, py;
    logic [2:0] c;
    logic       p;
    logic [7:0] xv;
    logic [6:0] yv;
    ew = (w > 32) ? 32 : w;
    eh = (h > 32) ? 32 : h;
    for (int dy = 0; dy < eh; dy++) begin
      for (int dx = 0; dx < ew; dx++) begin
        px = x + dx;
        py = y + dy;
        p  = (px < 160) && (py < 120);
        xv = 8'(px);
        yv = 7'(py);
        c  = col;
`ifdef WHACK_BORDER_EN
        if (dx == 0 || dx == ew - 1 || dy == 0 || dy == eh - 1) c = bcol;
`else
        if (bcol == ~col) c = col;
`endif
        exp_q.push_back({p, xv, yv, c});
      end
    end
  endtask

  // Driver: present a request and wait (bounded) for the handshake edge.
  // Returns #1 after the accepting edge; keep_valid leaves req_valid asserted.
  task automatic send_req(input int x, input int y, input int w, input int h,
                          input logic [2:0] col, input logic [2:0] bcol,
                          input bit keep_valid);
    int t;
    @(negedge clk);
    req_x      = 8'(x);
    req_y      = 7'(y);
    req_w      = WW'(w);
    req_h      = HW'(h);
    req_color  = col;
    req_bcolor = bcol;
    req_valid  = 1'b1;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  // Scoreboard: called #1 after the accepting edge; checks every slot, the
  // done pulse and the return of req_ready.
  task automatic check_draw(input string tag);
    logic [18:0] e;
    @(negedge clk);
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    check({tag, "_nready0"}, {31'd0, req_ready}, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check({tag, "_pix"}, {13'd0, plot, vga_x, vga_y, vga_color}, {13'd0, e});
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, {30'd0, done, plot}, 32'd2);
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, req_ready, done}, 32'd2);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_w      = '0;
    req_h      = '0;
    req_color  = '0;
    req_bcolor = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1: reset state
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_flags", {29'd0, plot, busy, done}, 32'd0);
    check("rst_xyc", {14'd0, vga_x, vga_y, vga_color}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // 2: basic 3x2 box
    model_box(10, 20, 3, 2, 3'b100, 3'b010);
    send_req(10, 20, 3, 2, 3'b100, 3'b010, 1'b0);
    check_draw("basic");

    // 3: clipping at the bottom-right corner
    model_box(158, 119, 4, 2, 3'b011, 3'b101);
    send_req(158, 119, 4, 2, 3'b011, 3'b101, 1'b0);
    check_draw("clip");

    // 3b: x past 255 keeps the 9-bit sum unclipped-by-wrap
    model_box(250, 5, 8, 1, 3'b110, 3'b001);
    send_req(250, 5, 8, 1, 3'b110, 3'b001, 1'b0);
    check_draw("xwide");

    // 4: zero-size boxes
    model_box(5, 5, 0, 5, 3'b111, 3'b000);
    send_req(5, 5, 0, 5, 3'b111, 3'b000, 1'b0);
    check_draw("w0");
    model_box(5, 5, 4, 0, 3'b111, 3'b000);
    send_req(5, 5, 4, 0, 3'b111, 3'b000, 1'b0);
    check_draw("h0");

    // 4b: width clamp (40 -> 32 slots)
    model_box(0, 50, 40, 1, 3'b001, 3'b100);
    send_req(0, 50, 40, 1, 3'b001, 3'b100, 1'b0);
    check_draw("clamp");

    // 5: back-pressure; valid held through the first draw
    model_box(40, 40, 4, 4, 3'b010, 3'b111);
    send_req(40, 40, 4, 4, 3'b010, 3'b111, 1'b1);
    req_x     = 8'd60;
    req_y     = 7'd60;
    req_color = 3'b101;
    check_draw("bp1");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_box(60, 60, 4, 4, 3'b101, 3'b111);
    check_draw("bp2");

    // 6: reset during slot 5 of a 4x4 draw
    send_req(20, 30, 4, 4, 3'b110, 3'b011, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_pre", {31'd0, plot}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_plot", {29'd0, plot, busy, done}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_nodone", {30'd0, done, busy}, 32'd0);
    end

    // 6b: 3x3 box; only the centre is interior in the border build
    model_box(1, 1, 3, 3, 3'b100, 3'b001);
    send_req(1, 1, 3, 3, 3'b100, 3'b001, 1'b0);
    check_draw("border");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
